// File: rtl/nlfsr_pkg.sv
// nlfsr_gen shared definitions: FSM state type, default geometry
// constants and the tap_pack helper used to build the TAPS parameter.
package nlfsr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN
   } nlfsr_state_e;

   localparam int N_DEF  = 17;
   localparam int K_DEF  = 5;
   // Width of one packed tap index for the default length: $clog2(N).
   localparam int TW_DEF = $clog2(N_DEF);

   typedef logic [K_DEF*TW_DEF-1:0] taps_t;

   // Packs five tap indices; t0 lands in the least significant field.
   function automatic taps_t tap_pack(
      input int t4,
      input int t3,
      input int t2,
      input int t1,
      input int t0
   );
      tap_pack = {TW_DEF'(t4), TW_DEF'(t3), TW_DEF'(t2),
                  TW_DEF'(t1), TW_DEF'(t0)};
   endfunction

endpackage

// File: rtl/nlfsr_gen_wgt_thresh.sv
// wgt_thresh: combinational weight threshold, hit = popcount(bits) >= THR.
// Ports: bits [K-1:0] in, hit out.
module wgt_thresh #(
   parameter int K   = 5,
   parameter int THR = 3
) (
   input  logic [K-1:0] bits,
   output logic         hit
);

   int cnt;

   always_comb begin
      cnt = 0;
      for (int i = 0; i < K; i++) begin
         cnt = cnt + int'(bits[i]);
      end
      hit = (cnt >= THR);
   end

endmodule

// File: rtl/nlfsr_gen.sv
// nlfsr_gen: seeded NLFSR with entropy warm-up, word packing behind a
// valid/ready handshake and sticky all-zero lockup detection.
// Ports: clk, rst (sync, active-high), ce_i, ent_i, seed_valid_i/
// seed_ready_o/seed_i, stop_i, out_valid_o/out_ready_i/out_data_o,
// a0_o (state bit 0), busy_o (not IDLE), lockup_o (sticky).
module nlfsr_gen
   import nlfsr_pkg::*;
#(
   parameter int N      = 17,
   parameter int K      = 5,
   parameter logic [K*$clog2(N)-1:0] TAPS = tap_pack(15, 10, 8, 7, 4),
   parameter int THR    = 3,
   parameter int WARMUP = 2 * N,
   parameter int OUT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_i,
   input  logic             ent_i,
   input  logic             seed_valid_i,
   output logic             seed_ready_o,
   input  logic [N-1:0]     seed_i,
   input  logic             stop_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o,
   output logic             a0_o,
   output logic             busy_o,
   output logic             lockup_o
);

   localparam int TW  = $clog2(N);
   localparam int WCW = $clog2(WARMUP + 1);
   localparam int BCW = $clog2(OUT_W + 1);

   nlfsr_state_e     st;
   logic [N-1:0]     a;
   logic [WCW-1:0]   wcnt;
   logic [BCW-1:0]   bcnt;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] acc_nx;
   logic [OUT_W-1:0] data;
   logic             valid;
   logic             lock;

   logic [K-1:0]     tbits;
   logic             f;
   logic             fb_run;
   logic             fb_init;
   logic             adv;
   logic             last_bit;

   always_comb begin
      tbits = '0;
      for (int i = 0; i < K; i++) begin
         tbits[i] = a[TAPS[i*TW +: TW]];
      end
   end

   wgt_thresh #(
      .K   (K),
      .THR (THR)
   ) u_wgt (
      .bits (tbits),
      .hit  (f)
   );

   assign fb_run  = a[0] ^ f;
   assign fb_init = fb_run ^ ent_i;

   // A held word blocks the generator so no bit is ever dropped.
   assign adv      = ce_i && !(valid && !out_ready_i);
   assign last_bit = (bcnt == BCW'(OUT_W - 1));

   // Newest bit enters at the MSB so the oldest ends up at the LSB.
   generate
      if (OUT_W == 1) begin : g_acc1
         assign acc_nx = a[0];
      end else begin : g_accn
         assign acc_nx = {a[0], acc[OUT_W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= IDLE;
         a     <= '0;
         wcnt  <= '0;
         bcnt  <= '0;
         acc   <= '0;
         data  <= '0;
         valid <= 1'b0;
         lock  <= 1'b0;
      end else begin
         unique case (st)
            IDLE: begin
               if (seed_valid_i && !stop_i) begin
                  a    <= seed_i;
                  wcnt <= '0;
                  bcnt <= '0;
                  lock <= 1'b0;
                  st   <= INIT;
               end
            end
            INIT: begin
               if (stop_i) begin
                  valid <= 1'b0;
                  bcnt  <= '0;
                  st    <= IDLE;
               end else if (ce_i) begin
                  a    <= {fb_init, a[N-1:1]};
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == WCW'(WARMUP - 1)) begin
                     st <= RUN;
                  end
               end
            end
            RUN: begin
               if (stop_i) begin
                  valid <= 1'b0;
                  bcnt  <= '0;
                  st    <= IDLE;
               end else if (a == '0) begin
                  lock  <= 1'b1;
                  valid <= 1'b0;
                  bcnt  <= '0;
                  st    <= IDLE;
               end else begin
                  if (valid && out_ready_i) begin
                     valid <= 1'b0;
                  end
                  if (adv) begin
                     a   <= {fb_run, a[N-1:1]};
                     acc <= acc_nx;
                     if (last_bit) begin
                        data  <= acc_nx;
                        valid <= 1'b1;
                        bcnt  <= '0;
                     end else begin
                        bcnt <= bcnt + 1'b1;
                     end
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign seed_ready_o = (st == IDLE);
   assign busy_o       = (st != IDLE);
   assign out_valid_o  = valid;
   assign out_data_o   = data;
   assign a0_o         = a[0];
   assign lockup_o     = lock;

endmodule

// File: tb/tb_nlfsr_gen.sv
// Self-checking bench for nlfsr_gen (default parameters): a bit-level
// model of the NLFSR rules predicts the word stream; directed tests.
module tb_nlfsr_gen;

   localparam int N      = 17;
   localparam int THR    = 3;
   localparam int WARMUP = 34;
   localparam int OUT_W  = 8;
   localparam int MAXW   = 40;
   localparam int TAPS_L [5] = '{15, 10, 8, 7, 4};

   logic             clk = 1'b0;
   logic             rst;
   logic             ce_i;
   logic             ent_i;
   logic             seed_valid_i;
   logic             seed_ready_o;
   logic [N-1:0]     seed_i;
   logic             stop_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [OUT_W-1:0] out_data_o;
   logic             a0_o;
   logic             busy_o;
   logic             lockup_o;

   nlfsr_gen dut (
      .clk          (clk),
      .rst          (rst),
      .ce_i         (ce_i),
      .ent_i        (ent_i),
      .seed_valid_i (seed_valid_i),
      .seed_ready_o (seed_ready_o),
      .seed_i       (seed_i),
      .stop_i       (stop_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .a0_o         (a0_o),
      .busy_o       (busy_o),
      .lockup_o     (lockup_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int rd_idx = 0;
   int base   = 0;
   int exp_n  = 0;
   logic [OUT_W-1:0] exp_w  [MAXW];
   logic [OUT_W-1:0] prev_w [MAXW];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: apply the update rule step by step on a plain bit array.
   function automatic logic [N-1:0] warm(input logic [N-1:0] seed,
                                         input int ent_mode,
                                         input int steps);
      int s [N];
      int cnt;
      int fb;
      int e;
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) s[i] = seed[i] ? 1 : 0;
      for (int k = 0; k < steps; k++) begin
         e = (ent_mode == 1 && (k % 2) == 0) ? 1 : 0;
         cnt = 0;
         for (int j = 0; j < 5; j++) cnt += s[TAPS_L[j]];
         fb = s[0] ^ ((cnt >= THR) ? 1 : 0) ^ e;
         for (int i = 0; i < N - 1; i++) s[i] = s[i+1];
         s[N-1] = fb;
      end
      for (int i = 0; i < N; i++) r[i] = (s[i] != 0);
      return r;
   endfunction

   task automatic fill_words(input logic [N-1:0] seed, input int ent_mode);
      logic [N-1:0] st;
      logic [OUT_W-1:0] w;
      st = warm(seed, ent_mode, WARMUP);
      for (int k = 0; k < MAXW; k++) begin
         w = '0;
         for (int b = 0; b < OUT_W; b++) begin
            w[b] = st[0];
            st = warm(st, 0, 1);
         end
         exp_w[k] = w;
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (out_valid_o) begin
            int idx;
            idx = rd_idx - base;
            if (idx >= exp_n) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %h, expected no word",
                        out_data_o);
            end else begin
               chk($sformatf("word[%0d]", idx), out_data_o, exp_w[idx]);
            end
            if (out_ready_i) rd_idx++;
         end
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_seed_ready"}, seed_ready_o, 1);
      chk({tag, "_out_valid"}, out_valid_o, 0);
      chk({tag, "_out_data"}, out_data_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_lockup"}, lockup_o, 0);
      chk({tag, "_a0"}, a0_o, 0);
   endtask

   task automatic stop_now();
      out_ready_i = 1'b1;
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("stop_busy", busy_o, 0);
      chk("stop_valid", out_valid_o, 0);
      chk("stop_seed_ready", seed_ready_o, 1);
   endtask

   task automatic run_seq(input logic [N-1:0] seed, input int ent_mode,
                          input int ce_per, input int nwords,
                          input int stall);
      int n;
      int first;
      int stall_left;
      logic held;
      fill_words(seed, ent_mode);
      base  = rd_idx;
      exp_n = MAXW;
      ce_i = 1'b0;
      ent_i = 1'b0;
      out_ready_i = 1'b1;
      seed_i = seed;
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      chk("busy_after_seed", busy_o, 1);
      n = 0;
      first = -1;
      held = 1'b0;
      stall_left = stall ? 20 : 0;
      while ((rd_idx - base) < nwords && n < 3000) begin
         ce_i  = ((n % ce_per) == 0);
         ent_i = (ent_mode == 1) && ((n % 2) == 0);
         if (first >= 0 && stall_left > 0) begin
            out_ready_i = 1'b0;
            stall_left--;
         end else begin
            out_ready_i = 1'b1;
         end
         tick();
         n++;
         if (first < 0 && out_valid_o) begin
            first = n;
            held = a0_o;
         end else if (first >= 0 && !out_ready_i) begin
            chk("a0_frozen_in_stall", a0_o, held);
         end
      end
      chk("words_received", (rd_idx - base) >= nwords, 1);
      // Seed edge is t; valid is seen after edge t+42 (cycle t+43)
      // when ce_i is always 1.
      chk("first_valid_edge", first,
          ce_per * (WARMUP + OUT_W - 1) + 1);
      ce_i = 1'b0;
      ent_i = 1'b0;
      stop_now();
   endtask

   initial begin
      int n;
      int diff;
      logic [N-1:0] st10;
      rst = 1'b1;
      ce_i = 1'b0;
      ent_i = 1'b0;
      seed_valid_i = 1'b0;
      seed_i = '0;
      stop_i = 1'b0;
      out_ready_i = 1'b1;
      fork
         monitor();
      join_none
      tick();
      tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Seed 1, no entropy: a lone bit rotates with period 17.
      run_seq(17'h00001, 0, 1, 16, 0);
      chk("model_w0", exp_w[0], 8'h01);
      chk("model_w1", exp_w[1], 8'h00);
      chk("model_w2", exp_w[2], 8'h02);
      chk("model_w4", exp_w[4], 8'h04);
      for (int i = 0; i < MAXW; i++) prev_w[i] = exp_w[i];

      // Same seed with entropy toggling from 1 during warm-up.
      run_seq(17'h00001, 1, 1, 16, 0);
      diff = 0;
      for (int i = 0; i < 16; i++) if (exp_w[i] != prev_w[i]) diff++;
      chk("entropy_changes_words", diff > 0, 1);

      // ce_i duty 1/3 with a 20-cycle back-pressure after word 0.
      run_seq(17'h0ACE1, 0, 3, 10, 1);

      // All-zero seed locks up at the first RUN cycle.
      base = rd_idx;
      exp_n = 0;
      ce_i = 1'b1;
      seed_i = '0;
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      for (n = 1; n <= 40; n++) begin
         tick();
         if (n == 34) begin
            chk("lock_pre_flag", lockup_o, 0);
            chk("lock_pre_busy", busy_o, 1);
         end
         if (n == 35) begin
            chk("lock_flag", lockup_o, 1);
            chk("lock_busy", busy_o, 0);
         end
      end
      chk("lock_sticky", lockup_o, 1);
      seed_i = 17'h00005;
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      chk("lock_cleared", lockup_o, 0);
      chk("reseed_busy", busy_o, 1);
      ce_i = 1'b0;
      stop_now();

      // Stop at INIT step 10: state must be kept.
      ce_i = 1'b1;
      seed_i = 17'h1ABCD;
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      repeat (10) tick();
      stop_now();
      st10 = warm(17'h1ABCD, 0, 10);
      chk("stop_keeps_a0", a0_o, st10[0]);
      ce_i = 1'b0;
      stop_i = 1'b1;
      seed_i = 17'h00005;
      seed_valid_i = 1'b1;
      tick();
      stop_i = 1'b0;
      seed_valid_i = 1'b0;
      chk("stop_blocks_seed", busy_o, 0);
      chk("stop_blocks_seed_a0", a0_o, st10[0]);
      run_seq(17'h00003, 0, 1, 6, 0);

      // Reset in the middle of RUN.
      fill_words(17'h1ABCD, 0);
      base = rd_idx;
      exp_n = MAXW;
      seed_i = 17'h1ABCD;
      seed_valid_i = 1'b1;
      tick();
      seed_valid_i = 1'b0;
      ce_i = 1'b1;
      repeat (60) tick();
      chk("pre_reset_busy", busy_o, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ce_i = 1'b0;
      check_reset("midrun_reset");
      tick();
      chk("post_reset_idle", busy_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
